// File: rtl/dma_controller.sv
// dma_controller: OAM sprite DMA ($4014) and DMC sample-fetch bus master with CPU halt/get-put alignment.
// Build option: define DMA_STALL_CNT_EN to add the stall_cycles counter output.
`default_nettype none

module dma_controller (
  input  logic        clk,
  input  logic        rst_l,
  input  logic        cpu_clk_en,
  input  logic [15:0] direct_addr,
  input  logic [7:0]  direct_data_in,
  input  logic        direct_we,
  input  logic        cpu_read_cycle,
  input  logic        dmc_re,
  input  logic [14:0] dmc_addr,
  input  logic [7:0]  mem_rd_data,
  output logic [15:0] dma_addr,
  output logic        dma_re,
  output logic        dma_we,
  output logic [7:0]  dma_wr_data,
  output logic        dma_active,
  output logic [7:0]  dmc_read_data,
  output logic        dmc_ack
`ifdef DMA_STALL_CNT_EN
  ,
  output logic [15:0] stall_cycles
`endif
);

  typedef enum logic [2:0] {
    IDLE, HALT, DUMMY, ALIGN, OAM_RD, OAM_WR, DMC_RD, RESUME
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic        phase;        // 0 = get cycle, 1 = put cycle
  logic [7:0]  page;
  logic [7:0]  idx;
  logic [7:0]  idx_nxt;
  logic        oam_pending;
  logic        dmc_req;
  logic        oam_start;

  // A request already acknowledged must not trigger a second fetch in the
  // cycle before the DMC side drops its level request.
  assign dmc_req   = dmc_re & ~dmc_ack;
  assign oam_start = direct_we & (direct_addr == 16'h4014) & ~oam_pending;
  assign idx_nxt   = (state == OAM_WR) ? idx + 8'd1 : idx;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = ((oam_pending | dmc_req) & cpu_read_cycle) ? HALT : IDLE;
      HALT:    state_nxt = dmc_req ? DUMMY : (phase ? OAM_RD : ALIGN);
      DUMMY:   state_nxt = phase ? DMC_RD : ALIGN;
      ALIGN:   state_nxt = dmc_req ? DMC_RD : (oam_pending ? OAM_RD : IDLE);
      OAM_RD:  state_nxt = OAM_WR;
      OAM_WR:  state_nxt = dmc_req ? DMC_RD : ((idx == 8'hFF) ? IDLE : OAM_RD);
      DMC_RD:  state_nxt = oam_pending ? RESUME : IDLE;
      RESUME:  state_nxt = OAM_RD;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are decoded from the state being entered so they line up with it.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state         <= IDLE;
      phase         <= 1'b0;
      page          <= 8'h00;
      idx           <= 8'h00;
      oam_pending   <= 1'b0;
      dma_addr      <= 16'h0000;
      dma_re        <= 1'b0;
      dma_we        <= 1'b0;
      dma_wr_data   <= 8'h00;
      dma_active    <= 1'b0;
      dmc_read_data <= 8'h00;
      dmc_ack       <= 1'b0;
    end else if (cpu_clk_en) begin
      state <= state_nxt;
      phase <= ~phase;
      idx   <= idx_nxt;
      if (oam_start) begin
        page        <= direct_data_in;
        oam_pending <= 1'b1;
      end
      if (state == OAM_WR && idx == 8'hFF) begin
        oam_pending <= 1'b0;
      end
      dma_active  <= (state_nxt != IDLE);
      dma_re      <= (state_nxt == OAM_RD) || (state_nxt == DMC_RD);
      dma_we      <= (state_nxt == OAM_WR);
      dma_addr    <= 16'h0000;
      dma_wr_data <= 8'h00;
      case (state_nxt)
        OAM_RD:  dma_addr <= {page, idx_nxt};
        OAM_WR: begin
          dma_addr    <= 16'h2004;
          dma_wr_data <= mem_rd_data;
        end
        DMC_RD:  dma_addr <= {1'b1, dmc_addr};
        default: ;
      endcase
      dmc_ack <= (state == DMC_RD);
      if (state == DMC_RD) begin
        dmc_read_data <= mem_rd_data;
      end
    end
  end

`ifdef DMA_STALL_CNT_EN
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      stall_cycles <= 16'h0000;
    end else if (cpu_clk_en && dma_active) begin
      stall_cycles <= stall_cycles + 16'd1;
    end
  end
`endif

endmodule

`default_nettype wire

// File: doc/dma_controller.md
DMA_CONTROLLER -- requirements
Module: dma_controller

Interface
REQ-001 SHALL have port clk  in  1  system clock.
REQ-002 SHALL have port rst_l  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have port cpu_clk_en  in  1  CPU-cycle strobe; state and outputs advance only on clk edges where it is high.
REQ-004 SHALL have ports direct_addr  in  16, direct_data_in  in  8, direct_we  in  1  CPU write bus, used to snoop $4014.
REQ-005 SHALL have port cpu_read_cycle  in  1  current CPU cycle is a read, so a halt is permitted.
REQ-006 SHALL have port dmc_re  in  1  DMC sample request, level, held until dmc_ack.
REQ-007 SHALL have port dmc_addr  in  15  DMC fetch offset; fetch address = {1'b1, dmc_addr}.
REQ-008 SHALL have port mem_rd_data  in  8  bus read data, valid in the same CPU cycle as dma_re.
REQ-009 SHALL have ports dma_addr  out  16, dma_re  out  1, dma_we  out  1, dma_wr_data  out  8  DMA bus master outputs.
REQ-010 SHALL have port dma_active  out  1  DMA owns the bus and the CPU is stalled (RDY low).
REQ-011 SHALL have ports dmc_read_data  out  8, dmc_ack  out  1  fetched DMC byte and its one-CPU-cycle valid strobe.
REQ-012 SHALL have port stall_cycles  out  16  count of CPU cycles with dma_active high; present only per REQ-030.

Function
REQ-013 SHALL keep phase bit: 0=get, 1=put, toggling on every cpu_clk_en.
REQ-014 SHALL, on direct_we with direct_addr==16'h4015 ignored and direct_addr==16'h4014, latch page=direct_data_in and set oam_pending; such writes while an OAM transfer is pending or active are ignored.
REQ-015 SHALL use states IDLE, HALT, DUMMY, ALIGN, OAM_RD, OAM_WR, DMC_RD, RESUME.
REQ-016 IDLE->HALT when (oam_pending | dmc_re) & cpu_read_cycle; otherwise remain in IDLE with dma_active=0.
REQ-017 HALT (1 cycle): if dmc_re, go to DUMMY; else go to OAM_RD if the next phase is get, otherwise ALIGN.
REQ-018 DUMMY (1 cycle, no bus access), then DMC_RD if the next phase is get, otherwise ALIGN.
REQ-019 ALIGN (1 put cycle, no bus access), then the pending read (DMC_RD priority over OAM_RD).
REQ-020 OAM_RD (get): dma_re=1, dma_addr={page, idx}, capture mem_rd_data; then OAM_WR.
REQ-021 OAM_WR (put): dma_we=1, dma_addr=16'h2004, dma_wr_data=captured byte, idx++ (8-bit); after idx 255 clear oam_pending; next state is DMC_RD if dmc_re, else OAM_RD, else IDLE.
REQ-022 DMC_RD (get): dma_re=1, dma_addr={1'b1, dmc_addr}; latch dmc_read_data and pulse dmc_ack for exactly one CPU cycle; then RESUME if oam_pending, else IDLE.
REQ-023 RESUME (put, no bus access) -> OAM_RD; a DMC steal during OAM adds exactly 2 cycles.
REQ-024 dma_active SHALL be 1 in every state except IDLE; dma_re/dma_we SHALL be 0 outside RD/WR states; all outputs SHALL be registered.
REQ-025 Standalone OAM transfer: HALT through last OAM_WR = 513 cycles if HALT is a put cycle, 514 if a get cycle.
REQ-026 Standalone DMC fetch: HALT through DMC_RD = 3 or 4 cycles.
REQ-027 If DMC and OAM are both pending at IDLE: a single HALT, DMC served first, then OAM without a second HALT.

Reset
REQ-028 rst_l low SHALL asynchronously force IDLE, phase=0, idx=0, page=0, oam_pending=0, and all outputs to 0, including during an active transfer; no bus access SHALL complete after reset.

Configuration
REQ-029 Macro DMA_STALL_CNT_EN SHALL gate the stall counter.
REQ-030 With DMA_STALL_CNT_EN: stall_cycles increments (wrapping at 16'hFFFF) on each cpu_clk_en with dma_active=1 and resets to 0. Without it: port and counter are absent; all other behaviour is identical.

Verification
REQ-031 Write $4014=8'h02 with HALT on a put cycle -> 256 reads $0200-$02FF each followed by a write to $2004 with the same data; dma_active high for 513 cycles.
REQ-032 Same stimulus with HALT on a get cycle -> one ALIGN cycle; 514 cycles.
REQ-033 dmc_re with dmc_addr=15'h4000 while idle -> read at 16'hC000; dmc_ack pulses once with mem_rd_data; 3 or 4 stall cycles by parity.
REQ-034 dmc_re asserted during OAM at idx=8'h40 -> one DMC read between OAM bytes, no byte lost or duplicated, total = base + 2 cycles.
REQ-035 rst_l low mid-OAM at idx=8'h80 -> dma_active=0 immediately; a subsequent $4014 write starts a fresh transfer at idx 0; stall_cycles=0 (DMA_STALL_CNT_EN builds).
